// File: rtl/uart_tx_word_if.sv
// uart_tx_word_if: word handshake and serial-line bundle between the UART APB
// slave (master side) and the word serializer (slave side).
interface uart_tx_word_if;
    logic        start;
    logic [31:0] To_TX;
    logic        tx;
    logic        busy;
    logic        Tx_done;

    modport master (
        output start,
        output To_TX,
        input  tx,
        input  busy,
        input  Tx_done
    );

    modport slave (
        input  start,
        input  To_TX,
        output tx,
        output busy,
        output Tx_done
    );
endinterface

// File: rtl/uart_tx_word.sv
// uart_tx_word: sends a 32-bit word as four back-to-back UART frames, LSB byte
// first. Frame is 8N1 by default; defining UART_TX_PARITY_EN inserts an even
// parity bit after the data bits (11-bit frame).
module uart_tx_word #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic           PCLK,
    input  logic           PRESET,
    uart_tx_word_if.slave  bus
);
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned BYTE_W   = 2;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BYTE_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     w_bit_cnt_nxt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [IDX_W-1:0]     w_bit_idx_nxt;
    logic [BYTE_W-1:0]    r_byte_idx;
    logic [BYTE_W-1:0]    w_byte_idx_nxt;
    logic [WORD_W-1:0]    r_shift_word;
    logic [WORD_W-1:0]    w_shift_word_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_bit_end;
    logic [BYTE_BITS-1:0] w_byte_nxt;

    // Last cycle of the current serial bit period
    assign w_bit_end = (r_bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // State and registered outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_shift_word <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_shift_word <= w_shift_word_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Next state; tx is derived from the next state so the line is registered
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_byte_idx_nxt   = r_byte_idx;
        w_shift_word_nxt = r_shift_word;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_tx_nxt         = 1'b1;
        w_byte_nxt       = '0;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (bus.start) begin
                    w_shift_word_nxt = bus.To_TX;
                    w_byte_idx_nxt   = '0;
                    w_bit_cnt_nxt    = '0;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    if (r_bit_idx == IDX_W'(BYTE_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    if (r_byte_idx == BYTE_W'(3)) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + BYTE_W'(1);
                        w_state_nxt    = S_START;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        w_byte_nxt = w_shift_word_nxt[{w_byte_idx_nxt, 3'b000} +: BYTE_BITS];
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_byte_nxt[w_bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = ^w_byte_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign bus.tx      = r_tx;
    assign bus.busy    = r_busy;
    assign bus.Tx_done = r_done;
endmodule

// File: tb/tb_uart_tx_word.sv
// tb_uart_tx_word: drives two serializers (4 and 2 clocks per bit) and checks
// them every cycle against a frame-arithmetic model, plus literal expectations.
module tb_uart_tx_word;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
    int first_frame[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
`else
    localparam int FB = 10;
    int first_frame[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
`endif
    localparam int L4   = 4 * FB * 4;
    localparam int L2   = 4 * FB * 2;
    localparam int MAXN = 512;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int   errors = 0;
    int   checks = 0;

    uart_tx_word_if b4 ();
    uart_tx_word_if b2 ();

    uart_tx_word #(.CLKS_PER_BIT(4)) u_dut4 (.PCLK(PCLK), .PRESET(PRESET), .bus(b4));
    uart_tx_word #(.CLKS_PER_BIT(2)) u_dut2 (.PCLK(PCLK), .PRESET(PRESET), .bus(b2));

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Expected line level t cycles after the accept edge of word w
    function automatic logic exp_line(input logic [31:0] w, input int t, input int c);
        int frame;
        int b;
        logic [7:0] by;
        frame = t / (c * FB);
        b     = (t / c) % FB;
        if (frame > 3) return 1'b1;
        by = w[frame*8 +: 8];
        if (b == 0) return 1'b0;
        if (b <= 8) return by[b-1];
        if (FB == 11 && b == 9) return ^by;
        return 1'b1;
    endfunction

    bit          m_active[2] = '{0, 0};
    int          m_t[2]      = '{0, 0};
    logic [31:0] m_word[2]   = '{32'h0, 32'h0};

    task automatic model_step(input int d, input int c, input logic st, input logic [31:0] w,
                              input logic tx, input logic busy, input logic done);
        logic done_now;
        logic exp_tx;
        done_now = 1'b0;
        if (PRESET) begin
            m_active[d] = 0;
        end else if (m_active[d]) begin
            m_t[d]++;
            if (m_t[d] == 4 * FB * c) begin
                m_active[d] = 0;
                done_now    = 1'b1;
            end
        end else if (st) begin
            m_active[d] = 1;
            m_word[d]   = w;
            m_t[d]      = 0;
        end
        exp_tx = m_active[d] ? exp_line(m_word[d], m_t[d], c) : 1'b1;
        chk($sformatf("dut%0d_tx", d), 32'(tx), 32'(exp_tx));
        chk($sformatf("dut%0d_busy", d), 32'(busy), 32'(m_active[d]));
        chk($sformatf("dut%0d_done", d), 32'(done), 32'(done_now));
    endtask

    // Cycle compare just after each active edge
    always @(posedge PCLK) begin
        #1;
        model_step(0, 4, b4.start, b4.To_TX, b4.tx, b4.busy, b4.Tx_done);
        model_step(1, 2, b2.start, b2.To_TX, b2.tx, b2.busy, b2.Tx_done);
    end

    logic rec[MAXN];

    // Record dut4 from cycle 0 (first negedge after accept) up to the Tx_done cycle
    task automatic track4(input int ev_at, input logic ev_start, input logic [31:0] ev_word,
                          input bit ev_pulse, output int busy_cycles, output int done_at);
        busy_cycles = 0;
        done_at     = -1;
        for (int n = 0; n < MAXN; n++) begin
            rec[n] = b4.tx;
            if (b4.busy) busy_cycles++;
            if (b4.Tx_done) done_at = n;
            if (n == ev_at) begin
                b4.start = ev_start;
                b4.To_TX = ev_word;
            end else if (ev_pulse && n == ev_at + 1) begin
                b4.start = 1'b0;
            end
            if (done_at >= 0) break;
            @(negedge PCLK);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc;
        int da;
        int cnt;
        b4.start = 1'b0; b4.To_TX = 32'h0;
        b2.start = 1'b0; b2.To_TX = 32'h0;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_tx4", 32'(b4.tx), 32'd1);
        chk("rst_busy4", 32'(b4.busy), 32'd0);
        chk("rst_done4", 32'(b4.Tx_done), 32'd0);
        chk("rst_tx2", 32'(b2.tx), 32'd1);
        PRESET = 1'b0;
        repeat (4) @(negedge PCLK);
        // Reset asserted while idle
        PRESET = 1'b1;
        #1;
        chk("idle_rst_tx", 32'(b4.tx), 32'd1);
        chk("idle_rst_busy", 32'(b4.busy), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (4) @(negedge PCLK);

        // Basic word with an ignored start pulse at cycle 50
        b4.start = 1'b1; b4.To_TX = 32'hA5C3_0F81;
        @(negedge PCLK);
        b4.start = 1'b0;
        track4(50, 1'b1, 32'hFFFF_FFFF, 1'b1, bc, da);
        chk("basic_busy_len", 32'(bc), 32'(L4));
        chk("basic_done_at", 32'(da), 32'(L4));
        chk("basic_idle_after", 32'(rec[L4]), 32'd1);
        for (int b = 0; b < 10; b++)
            chk($sformatf("basic_frame0_bit%0d", b), 32'(rec[b*4+1]), 32'(first_frame[b]));
        @(negedge PCLK);
        chk("basic_done_single", 32'(b4.Tx_done), 32'd0);
        repeat (3) @(negedge PCLK);

`ifdef UART_TX_PARITY_EN
        // Parity bits of 32'h0000_0007
        b4.start = 1'b1; b4.To_TX = 32'h0000_0007;
        @(negedge PCLK);
        b4.start = 1'b0;
        track4(-1, 1'b0, 32'h0, 1'b0, bc, da);
        chk("par_busy_len", 32'(bc), 32'd176);
        for (int f = 0; f < 4; f++)
            chk($sformatf("par_bit_frame%0d", f), 32'(rec[f*FB*4+9*4+1]), (f == 0) ? 32'd1 : 32'd0);
        repeat (3) @(negedge PCLK);
`endif

        // Back-to-back words with start held high
        b4.start = 1'b1; b4.To_TX = 32'h1234_5678;
        @(negedge PCLK);
        track4(10, 1'b1, 32'h0000_00FF, 1'b0, bc, da);
        chk("b2b_w0_busy_len", 32'(bc), 32'(L4));
        chk("b2b_w0_done_at", 32'(da), 32'(L4));
        chk("b2b_gap_busy", 32'(b4.busy), 32'd0);
        chk("b2b_gap_tx", 32'(b4.tx), 32'd1);
        chk("b2b_w0_last_data", 32'(rec[3*FB*4+8*4+1]), 32'd0);
        @(negedge PCLK);
        chk("b2b_w1_busy", 32'(b4.busy), 32'd1);
        chk("b2b_w1_start_bit", 32'(b4.tx), 32'd0);
        b4.start = 1'b0;
        track4(-1, 1'b0, 32'h0, 1'b0, bc, da);
        chk("b2b_w1_done_at", 32'(da), 32'(L4));
        chk("b2b_w1_byte0_bit0", 32'(rec[5]), 32'd1);
        chk("b2b_w1_byte1_bit0", 32'(rec[FB*4+5]), 32'd0);
        repeat (3) @(negedge PCLK);

        // Reset in the middle of DATA
        b4.start = 1'b1; b4.To_TX = 32'hA5C3_0F81;
        @(negedge PCLK);
        b4.start = 1'b0;
        repeat (10) @(negedge PCLK);
        chk("mid_pre_rst_tx", 32'(b4.tx), 32'd0);
        PRESET = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(b4.tx), 32'd1);
        chk("mid_rst_busy", 32'(b4.busy), 32'd0);
        chk("mid_rst_done", 32'(b4.Tx_done), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        cnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge PCLK);
            if (b4.busy || b4.Tx_done || !b4.tx) cnt++;
        end
        chk("post_rst_quiet", 32'(cnt), 32'd0);

        // Minimum divider
        b2.start = 1'b1; b2.To_TX = 32'h5555_5555;
        @(negedge PCLK);
        b2.start = 1'b0;
        bc = 0;
        da = -1;
        for (int n = 0; n < MAXN; n++) begin
            rec[n] = b2.tx;
            if (b2.busy) bc++;
            if (b2.Tx_done) begin
                da = n;
                break;
            end
            @(negedge PCLK);
        end
        chk("min_busy_len", 32'(bc), 32'(L2));
        chk("min_done_at", 32'(da), 32'(L2));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("min_data%0d_a", i), 32'(rec[2+2*i]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("min_data%0d_b", i), 32'(rec[3+2*i]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        repeat (5) @(negedge PCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
